// File: rtl/ps2_kbd_pkg.sv
// Shared constants, state encodings and event helpers for the PS/2 key event decoder.
// Event word layout is {ext, brk, code[7:0]}.
package ps2_kbd_pkg;

  localparam logic [7:0] BRK    = 8'hF0;
  localparam logic [7:0] EXT    = 8'hE0;
  localparam logic [7:0] PAUSE  = 8'hE1;
  localparam logic [7:0] BAT_OK = 8'hAA;
  localparam logic [7:0] ACK    = 8'hFA;
  localparam logic [7:0] RESEND = 8'hFE;
  localparam logic [7:0] KB_ERR = 8'hFF;
  localparam logic [7:0] KB_NUL = 8'h00;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int EV_W   = 32'sd10;
  localparam int EV_EXT = 32'sd9;
  localparam int EV_BRK = 32'sd8;

  localparam int MODE_BRK_ONLY  = 32'sd0;
  localparam int MODE_MAKE_ONLY = 32'sd1;
  localparam int MODE_BOTH      = 32'sd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } parse_state_e;

  // Keyboard status/handshake bytes that never describe a key.
  function automatic logic is_ignored(input logic [7:0] b);
    logic hit;
    case (b)
      BAT_OK, ACK, RESEND, KB_NUL, KB_ERR: hit = 1'b1;
      default:                             hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [EV_W-1:0] pack_event(input logic ext, input logic brk,
                                                 input logic [7:0] code);
    logic [EV_W-1:0] ev;
    ev         = {2'b00, code};
    ev[EV_EXT] = ext;
    ev[EV_BRK] = brk;
    return ev;
  endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Byte-stream input and key-event queue output of the PS/2 key event decoder.
// master = receiver/game-logic side, slave = decoder.
interface ps2_key_event_decoder_if;

  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rd_key_code;
  logic       clr_overflow;
  logic [9:0] key_code;
  logic       kb_buf_empty;
  logic       kb_buf_full;
  logic       overflow;

  modport master (
    output rx_done_tick, rx_data, rd_key_code, clr_overflow,
    input  key_code, kb_buf_empty, kb_buf_full, overflow
  );

  modport slave (
    input  rx_done_tick, rx_data, rd_key_code, clr_overflow,
    output key_code, kb_buf_empty, kb_buf_full, overflow
  );

endinterface

// File: rtl/ps2_key_event_decoder_fifo.sv
// Generic first-word-fall-through FIFO: B-bit words, 2**W entries, registered full/empty flags.
// A read while empty is ignored; a write while full succeeds only together with a read.
module ps2_key_event_decoder_fifo #(
  parameter int B = 10,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  output logic         empty,
  output logic         full,
  output logic [B-1:0] r_data
);

  logic [B-1:0] mem_r [2**W];
  logic [W-1:0] wr_ptr_r;
  logic [W-1:0] rd_ptr_r;
  logic [W-1:0] wr_ptr_nx_s;
  logic [W-1:0] rd_ptr_nx_s;
  logic [W-1:0] wr_ptr_inc_s;
  logic [W-1:0] rd_ptr_inc_s;
  logic         full_r;
  logic         empty_r;
  logic         full_nx_s;
  logic         empty_nx_s;
  logic         rd_ok_s;
  logic         wr_ok_s;

  assign rd_ok_s      = rd & ~empty_r;
  assign wr_ok_s      = wr & (~full_r | rd_ok_s);
  assign wr_ptr_inc_s = wr_ptr_r + W'(1'b1);
  assign rd_ptr_inc_s = rd_ptr_r + W'(1'b1);

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= w_data;
    end
  end

  // Pointer and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_nx_s;
      rd_ptr_r <= rd_ptr_nx_s;
      full_r   <= full_nx_s;
      empty_r  <= empty_nx_s;
    end
  end

  // Next pointer/flag values for read, write, or both.
  always_comb begin
    wr_ptr_nx_s = wr_ptr_r;
    rd_ptr_nx_s = rd_ptr_r;
    full_nx_s   = full_r;
    empty_nx_s  = empty_r;
    case ({wr_ok_s, rd_ok_s})
      2'b01: begin
        rd_ptr_nx_s = rd_ptr_inc_s;
        full_nx_s   = 1'b0;
        empty_nx_s  = (rd_ptr_inc_s == wr_ptr_r);
      end
      2'b10: begin
        wr_ptr_nx_s = wr_ptr_inc_s;
        empty_nx_s  = 1'b0;
        full_nx_s   = (wr_ptr_inc_s == rd_ptr_r);
      end
      2'b11: begin
        wr_ptr_nx_s = wr_ptr_inc_s;
        rd_ptr_nx_s = rd_ptr_inc_s;
      end
      default: begin
        wr_ptr_nx_s = wr_ptr_r;
        rd_ptr_nx_s = rd_ptr_r;
      end
    endcase
  end

  assign r_data = mem_r[rd_ptr_r];
  assign empty  = empty_r;
  assign full   = full_r;

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-set-2 byte-stream parser producing tagged make/break events into a FIFO.
// Handles E0/F0/E1 prefixes, MODE masking, typematic repeat filtering and sticky overflow.
module ps2_key_event_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int W_SIZE        = 2,
  parameter int MODE          = 2,
  parameter int REPEAT_FILTER = 1
) (
  input logic                   clk,
  input logic                   reset,
  ps2_key_event_decoder_if.slave bus
);

  parse_state_e    state_r;
  parse_state_e    state_nx_s;
  logic [2:0]      skip_cnt_r;
  logic [2:0]      skip_cnt_nx_s;
  logic            ev_valid_s;
  logic            ev_ext_s;
  logic            ev_brk_s;
  logic [7:0]      ev_code_s;
  logic [8:0]      last_make_r;
  logic            last_valid_r;
  logic            last_hit_s;
  logic            mode_ok_s;
  logic            repeat_hit_s;
  logic            accept_s;
  logic            rd_ok_s;
  logic            ovf_set_s;
  logic            overflow_r;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic [EV_W-1:0] fifo_head_s;

  // Parser state and pause-skip counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      skip_cnt_r <= 3'd0;
    end else begin
      state_r    <= state_nx_s;
      skip_cnt_r <= skip_cnt_nx_s;
    end
  end

  // Prefix parsing; an event is raised only on the byte that completes a sequence.
  always_comb begin
    state_nx_s    = state_r;
    skip_cnt_nx_s = skip_cnt_r;
    ev_valid_s    = 1'b0;
    ev_ext_s      = 1'b0;
    ev_brk_s      = 1'b0;
    ev_code_s     = bus.rx_data;
    if (bus.rx_done_tick) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.rx_data == BRK) begin
            state_nx_s = ST_BRK;
          end else if (bus.rx_data == EXT) begin
            state_nx_s = ST_EXT;
          end else if (bus.rx_data == PAUSE) begin
            state_nx_s    = ST_SKIP;
            skip_cnt_nx_s = PAUSE_SKIP;
          end else if (is_ignored(bus.rx_data)) begin
            state_nx_s = ST_IDLE;
          end else begin
            ev_valid_s = 1'b1;
          end
        end
        ST_EXT: begin
          if (bus.rx_data == BRK) begin
            state_nx_s = ST_EXT_BRK;
          end else if (bus.rx_data == EXT) begin
            state_nx_s = ST_EXT;
          end else begin
            ev_valid_s = 1'b1;
            ev_ext_s   = 1'b1;
            state_nx_s = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (bus.rx_data == BRK) begin
            state_nx_s = ST_BRK;
          end else begin
            ev_valid_s = 1'b1;
            ev_brk_s   = 1'b1;
            state_nx_s = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          ev_valid_s = 1'b1;
          ev_ext_s   = 1'b1;
          ev_brk_s   = 1'b1;
          state_nx_s = ST_IDLE;
        end
        ST_SKIP: begin
          skip_cnt_nx_s = skip_cnt_r - 3'd1;
          // The whole pause sequence collapses into one extended make of E1.
          if (skip_cnt_r == 3'd1) begin
            ev_valid_s = 1'b1;
            ev_ext_s   = 1'b1;
            ev_code_s  = PAUSE;
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_SKIP;
          end
        end
        default: begin
          state_nx_s    = ST_IDLE;
          skip_cnt_nx_s = 3'd0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  assign last_hit_s   = last_valid_r && (last_make_r == {ev_ext_s, ev_code_s});
  assign mode_ok_s    = ev_brk_s ? (MODE != MODE_MAKE_ONLY) : (MODE != MODE_BRK_ONLY);
  assign repeat_hit_s = (REPEAT_FILTER != 0) && !ev_brk_s && last_hit_s;
  assign accept_s     = ev_valid_s && mode_ok_s && !repeat_hit_s;
  assign rd_ok_s      = bus.rd_key_code & ~fifo_empty_s;
  assign ovf_set_s    = accept_s & fifo_full_s & ~rd_ok_s;

  // Held-key tracking for the repeat filter; any release of that key clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_make_r  <= 9'd0;
      last_valid_r <= 1'b0;
    end else if (accept_s && !ev_brk_s) begin
      last_make_r  <= {ev_ext_s, ev_code_s};
      last_valid_r <= 1'b1;
    end else if (ev_valid_s && ev_brk_s && last_hit_s) begin
      last_valid_r <= 1'b0;
    end
  end

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (ovf_set_s) begin
      overflow_r <= 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_r <= 1'b0;
    end
  end

  ps2_key_event_decoder_fifo #(
    .B (EV_W),
    .W (W_SIZE)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .rd     (bus.rd_key_code),
    .wr     (accept_s),
    .w_data (pack_event(ev_ext_s, ev_brk_s, ev_code_s)),
    .empty  (fifo_empty_s),
    .full   (fifo_full_s),
    .r_data (fifo_head_s)
  );

  assign bus.key_code     = fifo_head_s;
  assign bus.kb_buf_empty = fifo_empty_s;
  assign bus.kb_buf_full  = fifo_full_s;
  assign bus.overflow     = overflow_r;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Scoreboard bench: four decoder instances with different MODE/REPEAT_FILTER settings,
// one stimulated at a time; expected events queued at drive time and checked on pop.
module tb_ps2_key_event_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic [3:0] tick_v;
  logic [3:0] rd_v;
  logic [3:0] clr_v;
  wire  [9:0] kc [4];
  wire  [3:0] empty_w;
  wire  [3:0] full_w;
  wire  [3:0] ovf_w;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;

  // inst0: MODE=2 RF=1, inst1: MODE=0 RF=1, inst2: MODE=1 RF=1, inst3: MODE=2 RF=0
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int M  = (g == 1) ? 0 : ((g == 2) ? 1 : 2);
    localparam int RF = (g == 3) ? 0 : 1;
    ps2_key_event_decoder_if bus ();
    assign bus.rx_done_tick = tick_v[g];
    assign bus.rx_data      = rx_data;
    assign bus.rd_key_code  = rd_v[g];
    assign bus.clr_overflow = clr_v[g];
    assign kc[g]            = bus.key_code;
    assign empty_w[g]       = bus.kb_buf_empty;
    assign full_w[g]        = bus.kb_buf_full;
    assign ovf_w[g]         = bus.overflow;
    ps2_key_event_decoder #(.W_SIZE(2), .MODE(M), .REPEAT_FILTER(RF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic expect_ev(input logic [9:0] v);
    exp_q.push_back(v);
  endtask

  // One rx_done_tick to instance i, optionally with a read and/or overflow clear in the same cycle.
  task automatic send(input int i, input logic [7:0] b, input logic with_rd, input logic with_clr);
    @(negedge clk);
    rx_data   = b;
    tick_v[i] = 1'b1;
    rd_v[i]   = with_rd;
    clr_v[i]  = with_clr;
    @(negedge clk);
    tick_v = 4'b0000;
    rd_v   = 4'b0000;
    clr_v  = 4'b0000;
  endtask

  task automatic pop_check(input int i, input string tag);
    int guard = 0;
    while (empty_w[i] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_avail"}, empty_w[i], 1'b0);
    if (exp_q.size() > 0) check_eq(tag, kc[i], exp_q.pop_front());
    else check_eq({tag, "_sb"}, exp_q.size(), 16'd1);
    rd_v[i] = 1'b1;
    @(negedge clk);
    rd_v[i] = 1'b0;
  endtask

  task automatic end_check(input int i, input string tag);
    check_eq({tag, "_empty"}, empty_w[i], 1'b1);
    check_eq({tag, "_sb_left"}, exp_q.size(), 16'd0);
  endtask

  initial begin
    reset   = 1'b1;
    rx_data = 8'h00;
    tick_v  = 4'b0000;
    rd_v    = 4'b0000;
    clr_v   = 4'b0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq("rst_empty", empty_w[i], 1'b1);
      check_eq("rst_full", full_w[i], 1'b0);
      check_eq("rst_ovf", ovf_w[i], 1'b0);
    end

    // Break-only mode: the make is masked
    send(1, 8'h1C, 1'b0, 1'b0);
    send(1, 8'hF0, 1'b0, 1'b0);
    expect_ev(10'h11C);
    send(1, 8'h1C, 1'b0, 1'b0);
    pop_check(1, "brk_only");
    end_check(1, "brk_only");

    // Extended make then extended break
    send(0, 8'hE0, 1'b0, 1'b0);
    expect_ev(10'h275);
    send(0, 8'h75, 1'b0, 1'b0);
    check_eq("empty_fall", empty_w[0], 1'b0);
    send(0, 8'hE0, 1'b0, 1'b0);
    send(0, 8'hF0, 1'b0, 1'b0);
    expect_ev(10'h375);
    send(0, 8'h75, 1'b0, 1'b0);
    pop_check(0, "ext_make");
    pop_check(0, "ext_brk");
    end_check(0, "ext");

    // Typematic repeat filtered
    expect_ev(10'h01C);
    send(0, 8'h1C, 1'b0, 1'b0);
    send(0, 8'h1C, 1'b0, 1'b0);
    send(0, 8'h1C, 1'b0, 1'b0);
    send(0, 8'hF0, 1'b0, 1'b0);
    expect_ev(10'h11C);
    send(0, 8'h1C, 1'b0, 1'b0);
    expect_ev(10'h01C);
    send(0, 8'h1C, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) pop_check(0, "rep_filt");
    end_check(0, "rep_filt");

    // Repeats kept when the filter is off
    for (int k = 0; k < 3; k++) begin
      expect_ev(10'h01C);
      send(3, 8'h1C, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) pop_check(3, "rep_nofilt");
    send(3, 8'hF0, 1'b0, 1'b0);
    expect_ev(10'h11C);
    send(3, 8'h1C, 1'b0, 1'b0);
    expect_ev(10'h01C);
    send(3, 8'h1C, 1'b0, 1'b0);
    pop_check(3, "rep_nofilt_brk");
    pop_check(3, "rep_nofilt_make");
    end_check(3, "rep_nofilt");

    // Full, overflow, set-wins-over-clear, push+read while full
    expect_ev(10'h015); send(2, 8'h15, 1'b0, 1'b0);
    expect_ev(10'h01D); send(2, 8'h1D, 1'b0, 1'b0);
    expect_ev(10'h024); send(2, 8'h24, 1'b0, 1'b0);
    check_eq("not_full_3", full_w[2], 1'b0);
    expect_ev(10'h02D); send(2, 8'h2D, 1'b0, 1'b0);
    check_eq("full_4", full_w[2], 1'b1);
    check_eq("no_ovf_4", ovf_w[2], 1'b0);
    send(2, 8'h2C, 1'b0, 1'b0);
    check_eq("ovf_set", ovf_w[2], 1'b1);
    check_eq("full_after_drop", full_w[2], 1'b1);
    send(2, 8'h3C, 1'b0, 1'b1);
    check_eq("ovf_set_wins", ovf_w[2], 1'b1);
    clr_v[2] = 1'b1;
    @(negedge clk);
    clr_v[2] = 1'b0;
    check_eq("ovf_clr", ovf_w[2], 1'b0);
    check_eq("head_pre", kc[2], exp_q.pop_front());
    expect_ev(10'h033);
    send(2, 8'h33, 1'b1, 1'b0);
    check_eq("full_pushrd", full_w[2], 1'b1);
    check_eq("ovf_pushrd", ovf_w[2], 1'b0);
    for (int k = 0; k < 4; k++) pop_check(2, "drain");
    end_check(2, "drain");

    // Pause sequence yields one event
    send(0, 8'hE1, 1'b0, 1'b0);
    send(0, 8'h14, 1'b0, 1'b0);
    send(0, 8'h77, 1'b0, 1'b0);
    send(0, 8'hE1, 1'b0, 1'b0);
    send(0, 8'hF0, 1'b0, 1'b0);
    send(0, 8'h14, 1'b0, 1'b0);
    send(0, 8'hF0, 1'b0, 1'b0);
    check_eq("pause_pending", empty_w[0], 1'b1);
    expect_ev(10'h2E1);
    send(0, 8'h77, 1'b0, 1'b0);
    pop_check(0, "pause");
    end_check(0, "pause");

    // Reset discards a partial prefix
    send(0, 8'hE0, 1'b0, 1'b0);
    send(0, 8'hF0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_ev(10'h075);
    send(0, 8'h75, 1'b0, 1'b0);
    pop_check(0, "rst_prefix");
    end_check(0, "rst_prefix");

    // Push and read together while empty: push wins
    expect_ev(10'h04D);
    send(3, 8'h4D, 1'b1, 1'b0);
    pop_check(3, "pushrd_empty");
    end_check(3, "pushrd_empty");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
